// File: rtl/mux_8x1_rr_sched_pkg.sv
// Shared types and helpers for the 8-way round-robin mux scheduler.
// Holds the FSM state encoding, widths and the rotate-priority pick function.
package mux_sched_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   // Returns {found, idx}: first set bit of req scanning ptr, ptr+1, ... modulo 8.
   // The loop runs backwards so the lowest rotated offset is the last to write res.
   function automatic logic [SEL_W:0] pick_rr(input logic [N_REQ-1:0] req,
                                              input logic [SEL_W-1:0] ptr);
      logic [SEL_W-1:0] cand;
      logic [SEL_W:0]   res;
      res = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) res = {1'b1, cand};
      end
      return res;
   endfunction

endpackage

// File: rtl/mux_8x1_rr_sched_if.sv
// Request/data/grant bundle between the requesters (master) and the scheduler (slave).
interface mux_8x1_rr_sched_if;
   import mux_sched_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] din;
   logic [SEL_W-1:0] sel;
   logic [N_REQ-1:0] gnt;
   logic             valid;
   logic             F;

   modport master (output req, din, input sel, gnt, valid, F);
   modport slave  (input req, din, output sel, gnt, valid, F);

endinterface

// File: rtl/mux_8x1_rr_sched_sel.sv
// Generic behavioural 8:1 single-bit mux; purely combinational.
module mux_8x1_sel (
   input  logic [7:0] in_i,
   input  logic [2:0] s_i,
   output logic       y_o
);

   assign y_o = in_i[s_i];

endmodule

// File: rtl/mux_8x1_rr_sched.sv
// Round-robin owner of a shared 8:1 mux select; grant is registered one cycle after request,
// held up to MAX_HOLD cycles, and handed on with no idle bubble when another requester waits.
module mux_8x1_rr_sched
   import mux_sched_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   mux_8x1_rr_sched_if.slave   bus
);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic [SEL_W-1:0] ptr_after;
   logic [SEL_W:0]   pick_idle;
   logic [SEL_W:0]   pick_rel;
   logic             rel_w;
   logic             mux_y;

   // The released requester becomes lowest priority for the re-pick in the same cycle.
   assign ptr_after = sel_q + SEL_W'(1);
   assign pick_idle = pick_rr(bus.req, ptr_q);
   assign pick_rel  = pick_rr(bus.req, ptr_after);
   assign rel_w     = !bus.req[sel_q] || (hold_q == CNT_W'(MAX_HOLD - 1));

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      valid_d = valid_q;
      hold_d  = hold_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_idle[SEL_W]) begin
               state_d = ST_GRANT;
               sel_d   = pick_idle[SEL_W-1:0];
               gnt_d   = N_REQ'(1) << pick_idle[SEL_W-1:0];
               valid_d = 1'b1;
               hold_d  = '0;
            end
         end
         ST_GRANT: begin
            if (rel_w) begin
               ptr_d  = ptr_after;
               hold_d = '0;
               if (pick_rel[SEL_W]) begin
                  sel_d   = pick_rel[SEL_W-1:0];
                  gnt_d   = N_REQ'(1) << pick_rel[SEL_W-1:0];
                  valid_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
                  valid_d = 1'b0;
               end
            end else begin
               hold_d = hold_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         hold_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         hold_q  <= hold_d;
         ptr_q   <= ptr_d;
      end
   end

   mux_8x1_sel u_mux (
      .in_i (bus.din),
      .s_i  (sel_q),
      .y_o  (mux_y)
   );

   assign bus.sel   = sel_q;
   assign bus.gnt   = gnt_q;
   assign bus.valid = valid_q;
   assign bus.F     = valid_q & mux_y;

endmodule
